// File: rtl/deadlock_idx0_monitor.sv
// ----------------------------------------------------------------------------
// deadlock_idx0_monitor
//
// Per-kernel deadlock detector for an HLS-generated accelerator.
//
// The block samples AXI-Stream "port blocked" flags and sub-instance idle
// flags. It decides whether every active instance of the kernel is stalled
// on a stream. When that raw verdict holds for STABLE_CYCLES consecutive
// cycles, it raises a registered block flag. The flag is used only for
// simulation/debug reporting and does not touch the kernel datapath.
//
// Ports:
//   clock            in   1       kernel clock, rising edge
//   reset            in   1       asynchronous reset, active low
//   axis_block_sigs  in   N_AXIS  bit j = stream port j is blocked
//   inst_idle_sigs   in   N_INST  bit i = instance i is idle (bit 0 tied 0)
//   inst_block_sigs  in   1       external stall request for the kernel top
//   block            out  1       registered, debounced deadlock flag
// ----------------------------------------------------------------------------
module deadlock_idx0_monitor #(
    parameter int unsigned N_AXIS        = 4,
    parameter int unsigned N_INST        = 4,
    localparam int unsigned IDXW         = (N_INST > 1) ? $clog2(N_INST) : 1,
    parameter logic [N_AXIS*IDXW-1:0] AXIS_OWNER  = {2'd3, 2'd2, 2'd2, 2'd1},
    parameter logic [N_INST*IDXW-1:0] INST_PARENT = {2'd2, 2'd0, 2'd0, 2'd0},
    parameter int unsigned STABLE_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N_AXIS-1:0] axis_block_sigs,
    input  logic [N_INST-1:0] inst_idle_sigs,
    input  logic [0:0]        inst_block_sigs,
    output logic              block
);

    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);
    localparam logic [8:0] CNT_THR = 9'(STABLE_CYCLES);

    logic [N_INST-1:0] w_own_blk;
    logic [N_INST-1:0] w_sub_blk;
    logic [N_INST-1:0] w_stalled;
    logic              w_any_blk;
    logic              w_all_idle;
    logic              w_raw;
    logic              w_unused_idle0;

    logic [7:0]        r_cnt;
    logic              r_block;

    // Bit 0 of the idle vector is tied off by the integrator. The kernel
    // top's stall state comes from the external request instead.
    assign w_unused_idle0 = inst_idle_sigs[0];

    // Each stream contributes to the instance that owns it.
    always_comb begin
        w_own_blk = '0;
        for (int unsigned i = 0; i < N_INST; i++) begin
            for (int unsigned j = 0; j < N_AXIS; j++) begin
                if (AXIS_OWNER[j*IDXW +: IDXW] == IDXW'(i)) begin
                    w_own_blk[i] = w_own_blk[i] | axis_block_sigs[j];
                end
            end
        end
    end

    // Pushes child blocks up the static instance tree. N_INST relaxation
    // passes cover any tree depth without a combinational loop.
    always_comb begin
        w_sub_blk = w_own_blk;
        for (int unsigned p = 0; p < N_INST; p++) begin
            for (int unsigned k = 1; k < N_INST; k++) begin
                for (int unsigned i = 0; i < N_INST; i++) begin
                    if (INST_PARENT[k*IDXW +: IDXW] == IDXW'(i)) begin
                        w_sub_blk[i] = w_sub_blk[i] | w_sub_blk[k];
                    end
                end
            end
        end
    end

    always_comb begin
        w_stalled    = '0;
        w_stalled[0] = inst_block_sigs[0] | w_sub_blk[0];
        for (int unsigned i = 1; i < N_INST; i++) begin
            w_stalled[i] = inst_idle_sigs[i] | w_sub_blk[i];
        end
    end

    assign w_any_blk  = (|axis_block_sigs) | inst_block_sigs[0];
    assign w_all_idle = &inst_idle_sigs[N_INST-1:1];
    assign w_raw      = w_any_blk & (&w_stalled) & ~w_all_idle;

    // The counter saturates at STABLE_CYCLES. The flag uses counter + 1 so
    // that it rises on the STABLE_CYCLES-th consecutive edge with raw high.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_block <= 1'b0;
        end else begin
            if (w_raw) begin
                if (r_cnt < CNT_MAX) begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end else begin
                r_cnt <= '0;
            end
            r_block <= w_raw && (({1'b0, r_cnt} + 9'd1) >= CNT_THR);
        end
    end

    assign block = r_block;

endmodule

// File: tb/tb_deadlock_idx0_monitor.sv
module tb_deadlock_idx0_monitor;

    logic       clock;
    logic       reset;
    logic [3:0] axis_block_sigs;
    logic [3:0] inst_idle_sigs;
    logic [0:0] inst_block_sigs;
    logic       block;

    int n_vec;
    int n_err;

    typedef struct {
        logic [3:0] axis;
        logic [3:0] idle;
        logic       ext;
        logic       exp_block;
    } vec_t;

    vec_t vecs[$];

    deadlock_idx0_monitor #(
        .N_AXIS       (4),
        .N_INST       (4),
        .AXIS_OWNER   ({2'd3, 2'd2, 2'd2, 2'd1}),
        .INST_PARENT  ({2'd2, 2'd0, 2'd0, 2'd0}),
        .STABLE_CYCLES(2)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .axis_block_sigs(axis_block_sigs),
        .inst_idle_sigs (inst_idle_sigs),
        .inst_block_sigs(inst_block_sigs),
        .block          (block)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic exp);
        n_vec++;
        if (block !== exp) begin
            n_err++;
            $display("FAIL %s: block=%b expected=%b at %0t", name, block, exp, $time);
        end
    endtask

    task automatic drive(input logic [3:0] a, input logic [3:0] i, input logic e);
        axis_block_sigs    = a;
        inst_idle_sigs     = i;
        inst_block_sigs[0] = e;
    endtask

    // Inputs change on the falling edge. The output is sampled 1 time unit
    // after the rising edge that consumed those inputs.
    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic add(input logic [3:0] a, input logic [3:0] i, input logic e, input logic x);
        vec_t v;
        v.axis = a; v.idle = i; v.ext = e; v.exp_block = x;
        vecs.push_back(v);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;

        // Each row is one cycle: inputs, then the expected block value after the edge.
        add(4'b0000, 4'b0000, 1'b0, 1'b0); // nothing blocked
        add(4'b0001, 4'b1100, 1'b0, 1'b0); // single stall, 1st edge
        add(4'b0001, 4'b1100, 1'b0, 1'b1); // 2nd edge -> block
        add(4'b0001, 4'b1100, 1'b0, 1'b1); // held
        add(4'b0000, 4'b0000, 1'b0, 1'b0); // drop -> falls next edge
        add(4'b0010, 4'b0000, 1'b0, 1'b0); // partial stall
        add(4'b0010, 4'b0000, 1'b0, 1'b0);
        add(4'b0010, 4'b0000, 1'b0, 1'b0);
        add(4'b1001, 4'b0000, 1'b0, 1'b0); // hierarchy inst3->inst2
        add(4'b1001, 4'b0000, 1'b0, 1'b1);
        add(4'b0000, 4'b0000, 1'b0, 1'b0);
        add(4'b0001, 4'b1100, 1'b0, 1'b0); // glitch: raw up
        add(4'b0000, 4'b0000, 1'b0, 1'b0); // raw down one cycle
        add(4'b0001, 4'b1100, 1'b0, 1'b0); // requalify from scratch
        add(4'b0001, 4'b1100, 1'b0, 1'b1);
        add(4'b0000, 4'b0000, 1'b0, 1'b0); // drop while block=1
        add(4'b0000, 4'b1110, 1'b0, 1'b0); // all idle
        add(4'b0000, 4'b1110, 1'b1, 1'b0); // all idle + external
        add(4'b0000, 4'b1110, 1'b1, 1'b0);
        add(4'b1000, 4'b0110, 1'b1, 1'b0); // external + inst3 blocked
        add(4'b1000, 4'b0110, 1'b1, 1'b1);
        add(4'b1000, 4'b0110, 1'b1, 1'b1);
        add(4'b0000, 4'b0000, 1'b1, 1'b0); // external alone, inst1 active
        add(4'b0000, 4'b0000, 1'b1, 1'b0);
        add(4'b0100, 4'b0010, 1'b0, 1'b0); // inst3 neither idle nor blocked
        add(4'b0100, 4'b0010, 1'b0, 1'b0);

        // Reset held with a raw-high input pattern
        reset = 1'b0;
        drive(4'hF, 4'b0000, 1'b0);
        #1;
        check("reset_initial", 1'b0);
        for (int c = 0; c < 4; c++) begin
            step();
            check("reset_held", 1'b0);
        end
        @(negedge clock);
        reset = 1'b1;
        step();
        check("reset_release_edge1", 1'b0);
        step();
        check("reset_release_edge2", 1'b1);

        // Asynchronous reset in the middle of a cycle clears both the flag and the counter
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_mid", 1'b0);
        @(negedge clock);
        reset = 1'b1;
        step();
        check("post_async_edge1", 1'b0);
        step();
        check("post_async_edge2", 1'b1);

        // Return to a quiet state before running the table
        @(negedge clock);
        drive(4'b0000, 4'b0000, 1'b0);
        step();
        check("quiet", 1'b0);

        foreach (vecs[k]) begin
            @(negedge clock);
            drive(vecs[k].axis, vecs[k].idle, vecs[k].ext);
            step();
            check($sformatf("vec%0d", k), vecs[k].exp_block);
        end

        // Partial stall held for a long time never raises block
        @(negedge clock);
        drive(4'b0010, 4'b0000, 1'b0);
        for (int c = 0; c < 10; c++) begin
            step();
            check("partial_long", 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
